cin_input_buffer: RTL and testbench

- Console-input (Cin) side of the emulator stdio path; the reader counterpart of the Cout capture logic in the MS6205 front-panel display block.
- Queues keyboard symbols in a FIFO.
- Delivers one symbol per CPU Cin request over a 4-phase req/ack handshake, the same handshake style as the Cout/CioAcq path.
- Emits an echo strobe so the display path can mirror typed input.

---
 rtl/cin_input_buffer.sv | 175 +++++++++++++++++
 tb/tb_cin_input_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cin_input_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cin_input_buffer
//  Purpose  : Console-input (Cin) buffer. Queues keyboard symbols in a FIFO
//             and hands one symbol to the CPU per Cin request over a 4-phase
//             req/ack handshake. Each accepted key produces a one-cycle echo
//             strobe so the display path can mirror typed input.
//             All state updates on the falling edge of Clk.
//  Ports    : Clk, Rst_n          - clock (falling edge), async active-low reset
//             key_symbol/key_valid- keyboard decoder symbol + one-cycle strobe
//             flush               - synchronous FIFO clear
//             Cin                 - CPU input request (level)
//             CinAcq/CinData      - acknowledge and delivered symbol
//             echo_valid/echo_symbol - echo of each accepted key
//             count/empty/full    - registered FIFO occupancy status
//             overflow            - sticky; key dropped because FIFO was full
//  Revision : 1.0 - initial release
// ============================================================================
module cin_input_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [WIDTH-1:0]  key_symbol,
    input  logic              key_valid,
    input  logic              flush,
    input  logic              Cin,
    output logic              CinAcq,
    output logic [WIDTH-1:0]  CinData,
    output logic              echo_valid,
    output logic [WIDTH-1:0]  echo_symbol,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              overflow_q, overflow_d;
    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  cin_data_q, cin_data_d;
    logic              echo_valid_q;
    logic [WIDTH-1:0]  echo_symbol_q, echo_symbol_d;

    logic key_offer;
    logic do_pop;
    logic do_push;

    // A zero symbol is the decoder's "no key" code and is never a real offer.
    assign key_offer = key_valid && (key_symbol != '0);

    // Pop only on a pending request that the FSM has not served yet. Flush
    // blocks the pop so a cleared FIFO is never read on the same edge.
    assign do_pop = !flush && !empty_q && Cin &&
                    ((state_q == S_IDLE) || (state_q == S_WAIT));

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign do_push = !flush && key_offer && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        cin_data_d    = cin_data_q;
        echo_symbol_d = echo_symbol_q;
        state_d       = state_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d      = wr_ptr_q + PTR_ONE;
                echo_symbol_d = key_symbol;
            end else if (key_offer) begin
                overflow_d = 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                cin_data_d = mem_q[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (do_pop) begin
                    state_d = S_ACK;
                end else if (Cin) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!Cin) begin
                    state_d = S_IDLE;
                end else if (do_pop) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // CinData is held here; flush does not disturb a delivery.
                if (!Cin) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(negedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= key_symbol;
        end
    end

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= S_IDLE;
            cin_data_q    <= '0;
            echo_valid_q  <= 1'b0;
            echo_symbol_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= (count_d == '0);
            full_q        <= (count_d == DEPTH_CNT);
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            cin_data_q    <= cin_data_d;
            echo_valid_q  <= do_push;
            echo_symbol_q <= echo_symbol_d;
        end
    end

    // CinAcq is decoded from the state register so reset drops it at once.
    assign CinAcq      = (state_q == S_ACK);
    assign CinData     = cin_data_q;
    assign echo_valid  = echo_valid_q;
    assign echo_symbol = echo_symbol_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cin_input_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cin_input_buffer
//  Purpose  : Directed self-checking bench for cin_input_buffer. Inputs are
//             driven at the rising edge, the DUT updates on the falling edge,
//             and outputs are sampled at the following rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cin_input_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int WIDTH  = 8;

    logic              Clk;
    logic              Rst_n;
    logic [WIDTH-1:0]  key_symbol;
    logic              key_valid;
    logic              flush;
    logic              Cin;
    logic              CinAcq;
    logic [WIDTH-1:0]  CinData;
    logic              echo_valid;
    logic [WIDTH-1:0]  echo_symbol;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;

    cin_input_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .key_symbol  (key_symbol),
        .key_valid   (key_valid),
        .flush       (flush),
        .Cin         (Cin),
        .CinAcq      (CinAcq),
        .CinData     (CinData),
        .echo_valid  (echo_valid),
        .echo_symbol (echo_symbol),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One DUT update: falling edge, then back to the rising edge to sample/drive.
    task automatic step();
        @(negedge Clk);
        @(posedge Clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] sym);
        key_valid  = 1'b1;
        key_symbol = sym;
        step();
        key_valid  = 1'b0;
        key_symbol = '0;
    endtask

    initial begin
        Rst_n      = 1'b0;
        key_symbol = '0;
        key_valid  = 1'b0;
        flush      = 1'b0;
        Cin        = 1'b0;
        step();
        step();

        // ---------------- reset state ----------------
        check("rst_acq",   CinAcq,      0);
        check("rst_data",  CinData,     0);
        check("rst_count", count,       0);
        check("rst_empty", empty,       1);
        check("rst_full",  full,        0);
        check("rst_ovf",   overflow,    0);
        check("rst_echo",  echo_valid,  0);
        check("rst_esym",  echo_symbol, 0);
        Rst_n = 1'b1;
        step();

        // ---------------- basic push / pop ----------------
        push(8'h41);
        check("pA_echo",  echo_valid,  1);
        check("pA_esym",  echo_symbol, 8'h41);
        check("pA_count", count,       1);
        check("pA_empty", empty,       0);
        push(8'h42);
        check("pB_count", count,       2);
        check("pB_esym",  echo_symbol, 8'h42);
        step();
        check("echo_drop", echo_valid, 0);

        Cin = 1'b1; step();
        check("r1_acq",   CinAcq,  1);
        check("r1_data",  CinData, 8'h41);
        check("r1_count", count,   1);
        step();
        check("r1_hold",  CinAcq,  1);
        check("r1_count_hold", count, 1);
        Cin = 1'b0; step();
        check("r1_rel",   CinAcq,  0);
        Cin = 1'b1; step();
        check("r2_acq",   CinAcq,  1);
        check("r2_data",  CinData, 8'h42);
        check("r2_empty", empty,   1);
        Cin = 1'b0; step();
        check("r2_rel",   CinAcq,  0);
        check("idle_data", CinData, 8'h42);

        // ---------------- request while empty ----------------
        Cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_acq", CinAcq, 0);
        end
        push(8'h31);
        check("w_nobypass", CinAcq, 0);
        check("w_count",    count,  1);
        step();
        check("w_acq",   CinAcq,  1);
        check("w_data",  CinData, 8'h31);
        check("w_count0", count,  0);
        Cin = 1'b0; step();
        check("w_rel", CinAcq, 0);

        // ---------------- fill past full (pointers start at 3 -> wrap) ----------------
        for (int i = 0; i < 17; i++) begin
            push(8'(8'h41 + i));
            check("fill_echo", echo_valid, (i < 16) ? 1 : 0);
        end
        check("full_flag",  full,     1);
        check("full_count", count,    16);
        check("full_ovf",   overflow, 1);
        check("full_esym",  echo_symbol, 8'h50);

        // ---------------- pop and push on the same edge while full ----------------
        Cin = 1'b1;
        push(8'h60);
        check("pp_acq",   CinAcq,     1);
        check("pp_data",  CinData,    8'h41);
        check("pp_count", count,      16);
        check("pp_full",  full,       1);
        check("pp_ovf",   overflow,   1);
        check("pp_echo",  echo_valid, 1);
        Cin = 1'b0; step();
        check("pp_rel", CinAcq, 0);

        for (int i = 0; i < 15; i++) begin
            Cin = 1'b1; step();
            check("drain_acq",  CinAcq,  1);
            check("drain_data", CinData, 8'(8'h42 + i));
            Cin = 1'b0; step();
        end
        Cin = 1'b1; step();
        check("drain_last", CinData, 8'h60);
        check("drain_empty", empty,  1);
        check("drain_ovf",  overflow, 1);
        Cin = 1'b0; step();

        // ---------------- zero symbol ----------------
        push(8'h00);
        check("zero_echo",  echo_valid, 0);
        check("zero_count", count,      0);
        check("zero_ovf",   overflow,   1);

        // ---------------- flush during ACK ----------------
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        Cin = 1'b1; step();
        check("fl_acq0",   CinAcq,  1);
        check("fl_data0",  CinData, 8'h11);
        check("fl_count0", count,   3);
        flush = 1'b1;
        push(8'h77);
        flush = 1'b0;
        check("fl_count", count,      0);
        check("fl_empty", empty,      1);
        check("fl_ovf",   overflow,   0);
        check("fl_acq",   CinAcq,     1);
        check("fl_data",  CinData,    8'h11);
        check("fl_echo",  echo_valid, 0);
        step();
        check("fl_acq2",  CinAcq,  1);
        check("fl_data2", CinData, 8'h11);
        Cin = 1'b0; step();
        check("fl_rel",   CinAcq,  0);

        // ---------------- asynchronous reset mid-handshake ----------------
        for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
        Cin = 1'b1; step();
        check("ar_acq0",   CinAcq, 1);
        check("ar_count0", count,  4);
        #2 Rst_n = 1'b0;
        #1;
        check("ar_acq",   CinAcq, 0);
        check("ar_count", count,  0);
        check("ar_empty", empty,  1);
        Cin = 1'b0;
        @(posedge Clk);
        Rst_n = 1'b1;
        step();
        check("ar_post", CinAcq, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
